// File: rtl/kt8_sequencer_if.sv
// Bus bundle between the KT8 fetch/execute sequencer (master) and the
// datapath/memory side (slave).
// Handshake: mem_req_o is a valid that stays high, with mem_addr_o and mem_we_o
// held stable, until the cycle mem_ready_i is high. That cycle completes the
// transfer, and mem_rdata_i is valid in that same cycle for reads.
interface kt8_sequencer_if;
    logic       run_i;
    logic       step_i;
    logic       zero_i;
    logic       mem_req_o;
    logic       mem_we_o;
    logic [7:0] mem_addr_o;
    logic       mem_ready_i;
    logic [7:0] mem_rdata_i;
    logic [7:0] ir_o;
    logic       exec_o;
    logic [7:0] pc_o;
    logic       halted_o;
    logic       fault_o;
    logic [2:0] state_o;

    modport master (
        input  run_i, step_i, zero_i, mem_ready_i, mem_rdata_i,
        output mem_req_o, mem_we_o, mem_addr_o, ir_o, exec_o, pc_o,
               halted_o, fault_o, state_o
    );

    modport slave (
        output run_i, step_i, zero_i, mem_ready_i, mem_rdata_i,
        input  mem_req_o, mem_we_o, mem_addr_o, ir_o, exec_o, pc_o,
               halted_o, fault_o, state_o
    );
endinterface

// File: rtl/kt8_sequencer.sv
// KT8 fetch/execute controller: owns PC and IR, sequences instructions through
// one shared memory port and issues one exec_o commit strobe per instruction.
module kt8_sequencer #(
    parameter logic [7:0]  RESET_PC    = 8'h00,
    parameter logic [7:0]  DATA_BASE   = 8'hE0,
    parameter int unsigned BUS_TIMEOUT = 15
) (
    input  logic            clk_i,
    input  logic            rst_i,
    kt8_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_HALT  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    localparam logic [7:0] TIMEOUT = 8'(BUS_TIMEOUT);

    state_t     state, state_nx;
    logic [7:0] pc, pc_nx;
    logic [7:0] ir, ir_nx;
    logic [7:0] wait_cnt, wait_nx;
    logic       is_mem_op;
    logic [7:0] disp;

    // Opcode groups 000/001/010 are the load/load/store forms that need MEM.
    assign is_mem_op = (ir[7:5] == 3'b000) || (ir[7:5] == 3'b001) || (ir[7:5] == 3'b010);
    assign disp      = {4'h0, ir[3:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            ir       <= 8'h00;
            wait_cnt <= 8'h00;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            ir       <= ir_nx;
            wait_cnt <= wait_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        pc_nx          = pc;
        ir_nx          = ir;
        wait_nx        = 8'h00;
        bus.mem_req_o  = 1'b0;
        bus.mem_we_o   = 1'b0;
        bus.mem_addr_o = pc;
        bus.exec_o     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.run_i || bus.step_i) state_nx = S_FETCH;
            end
            S_FETCH: begin
                bus.mem_req_o = 1'b1;
                if (bus.mem_ready_i) begin
                    ir_nx    = bus.mem_rdata_i;
                    pc_nx    = pc + 8'd1;
                    state_nx = S_EXEC;
                end else if (wait_cnt == TIMEOUT) begin
                    state_nx = S_FAULT;
                end else begin
                    wait_nx = wait_cnt + 8'd1;
                end
            end
            S_EXEC: begin
                if (is_mem_op) begin
                    state_nx = S_MEM;
                end else begin
                    bus.exec_o = 1'b1;
                    // Displacements are relative to the already-incremented PC.
                    case (ir[7:4])
                        4'b1001: pc_nx = pc + disp;
                        4'b1010: pc_nx = pc - disp;
                        4'b1100: pc_nx = bus.zero_i ? pc + disp : pc;
                        default: pc_nx = pc;
                    endcase
                    if (ir[7:4] == 4'b1111) state_nx = S_HALT;
                    else                    state_nx = bus.run_i ? S_FETCH : S_IDLE;
                end
            end
            S_MEM: begin
                bus.mem_req_o  = 1'b1;
                bus.mem_addr_o = DATA_BASE | {3'b000, ir[4:0]};
                bus.mem_we_o   = (ir[7:5] == 3'b010);
                if (bus.mem_ready_i) begin
                    // A ready arriving together with reset must not commit.
                    bus.exec_o = !rst_i;
                    state_nx   = bus.run_i ? S_FETCH : S_IDLE;
                end else if (wait_cnt == TIMEOUT) begin
                    state_nx = S_FAULT;
                end else begin
                    wait_nx = wait_cnt + 8'd1;
                end
            end
            default: begin
                state_nx = state;
            end
        endcase
    end

    assign bus.ir_o     = ir;
    assign bus.pc_o     = pc;
    assign bus.halted_o = (state == S_HALT);
    assign bus.fault_o  = (state == S_FAULT);
    assign bus.state_o  = state;
endmodule

// File: tb/tb_kt8_sequencer.sv
// Bench for kt8_sequencer: cycle table, directed multi-cycle sequences and a
// randomized program checked against an instruction-level reference model.
module tb_kt8_sequencer;
    localparam logic [7:0] DATA_BASE = 8'hE0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    kt8_sequencer_if bus ();

    kt8_sequencer dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst;
        logic       run;
        logic       ready;
        logic [7:0] rdata;
        logic       req;
        logic [7:0] addr;
        logic       ex;
        logic [7:0] pc;
        logic [7:0] ir;
        logic       halted;
    } vec_t;

    logic [17:0] exp_q[$];
    logic [7:0]  mem [256];
    logic        zbit [256];
    logic [7:0]  m_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic r, input logic run, input logic step, input logic zero,
                        input logic ready, input logic [7:0] rdata);
        @(negedge clk);
        rst             = r;
        bus.run_i       = run;
        bus.step_i      = step;
        bus.zero_i      = zero;
        bus.mem_ready_i = ready;
        bus.mem_rdata_i = rdata;
        #1;
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic expect_bus(input string tag, input logic req, input logic we,
                              input logic [7:0] addr, input logic ex);
        chk({tag, ".req"},  32'(bus.mem_req_o), 32'(req));
        chk({tag, ".we"},   32'(bus.mem_we_o),  32'(we));
        chk({tag, ".addr"}, 32'(bus.mem_addr_o), 32'(addr));
        chk({tag, ".exec"}, 32'(bus.exec_o),    32'(ex));
    endtask

    task automatic fetch_seq(input logic [7:0] addr, input logic [7:0] data, input int waits,
                             input logic run, input logic step);
        for (int i = 0; i < waits; i++) begin
            tick(1'b0, run, step, 1'b0, 1'b0, 8'h00);
            expect_bus("fetch_wait", 1'b1, 1'b0, addr, 1'b0);
            chk("fetch_wait.fault", 32'(bus.fault_o), 32'd0);
        end
        tick(1'b0, run, step, 1'b0, 1'b1, data);
        expect_bus("fetch", 1'b1, 1'b0, addr, 1'b0);
    endtask

    task automatic exec_seq(input logic ex, input logic [7:0] pc, input logic [7:0] ir,
                            input logic run, input logic step, input logic zero);
        tick(1'b0, run, step, zero, 1'b0, 8'h00);
        chk("exec.strobe", 32'(bus.exec_o),    32'(ex));
        chk("exec.pc",     32'(bus.pc_o),      32'(pc));
        chk("exec.ir",     32'(bus.ir_o),      32'(ir));
        chk("exec.req",    32'(bus.mem_req_o), 32'd0);
    endtask

    // Instruction-level model: one call retires one instruction from m_pc.
    task automatic model_instr();
        logic [7:0] op;
        logic [7:0] a;
        op = mem[m_pc];
        exp_q.push_back({2'd1, m_pc, 8'h00});
        m_pc = m_pc + 8'd1;
        if (op[7:5] <= 3'd2) begin
            a = DATA_BASE | {3'b000, op[4:0]};
            exp_q.push_back({2'd3, a, 7'b0, op[7:5] == 3'd2});
            exp_q.push_back({2'd2, op, m_pc});
        end else begin
            exp_q.push_back({2'd2, op, m_pc});
            if (op[7:4] == 4'h9) m_pc = m_pc + {4'h0, op[3:0]};
            if (op[7:4] == 4'hA) m_pc = m_pc - {4'h0, op[3:0]};
            if (op[7:4] == 4'hC && zbit[m_pc]) m_pc = m_pc + {4'h0, op[3:0]};
        end
    endtask

    initial begin
        vec_t vecs[10];
        logic [7:0] p;

        bus.run_i = 1'b0; bus.step_i = 1'b0; bus.zero_i = 1'b0;
        bus.mem_ready_i = 1'b0; bus.mem_rdata_i = 8'h00;

        // Zero-wait program [61, 85, F0] as a cycle table; row 1 is cycle 0.
        vecs[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 8'h61, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 8'h01, 8'h61, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 8'h85, 1'b1, 8'h01, 1'b0, 8'h01, 8'h61, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h02, 1'b1, 8'h02, 8'h85, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 8'hF0, 1'b1, 8'h02, 1'b0, 8'h02, 8'h85, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h03, 1'b1, 8'h03, 8'hF0, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h03, 1'b0, 8'h03, 8'hF0, 1'b1};
        vecs[9] = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h03, 1'b0, 8'h03, 8'hF0, 1'b1};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick(vecs[i].rst, vecs[i].run, 1'b0, 1'b0, vecs[i].ready, vecs[i].rdata);
            expect_bus($sformatf("vec%0d", i), vecs[i].req, 1'b0, vecs[i].addr, vecs[i].ex);
            chk($sformatf("vec%0d.pc", i),     32'(bus.pc_o),     32'(vecs[i].pc));
            chk($sformatf("vec%0d.ir", i),     32'(bus.ir_o),     32'(vecs[i].ir));
            chk($sformatf("vec%0d.halted", i), 32'(bus.halted_o), 32'(vecs[i].halted));
            chk($sformatf("vec%0d.fault", i),  32'(bus.fault_o),  32'd0);
        end

        // Store with two wait states, then self-loop jump at 0x20.
        do_reset();
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        fetch_seq(8'h00, 8'h9F, 0, 1'b1, 1'b0);
        exec_seq(1'b1, 8'h01, 8'h9F, 1'b1, 1'b0, 1'b0);
        fetch_seq(8'h10, 8'h43, 0, 1'b1, 1'b0);
        exec_seq(1'b0, 8'h11, 8'h43, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            expect_bus("store_wait", 1'b1, 1'b1, 8'hE3, 1'b0);
        end
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        expect_bus("store_ready", 1'b1, 1'b1, 8'hE3, 1'b1);
        fetch_seq(8'h11, 8'h9E, 0, 1'b1, 1'b0);
        exec_seq(1'b1, 8'h12, 8'h9E, 1'b1, 1'b0, 1'b0);
        fetch_seq(8'h20, 8'hA1, 0, 1'b1, 1'b0);
        exec_seq(1'b1, 8'h21, 8'hA1, 1'b1, 1'b0, 1'b0);
        fetch_seq(8'h20, 8'hF0, 1, 1'b1, 1'b0);
        exec_seq(1'b1, 8'h21, 8'hF0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
        expect_bus("halt", 1'b0, 1'b0, 8'h21, 1'b0);
        chk("halt.halted", 32'(bus.halted_o), 32'd1);

        // Backward wrap, forward wrap, conditional jump not taken and taken.
        do_reset();
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        fetch_seq(8'h00, 8'hA3, 0, 1'b1, 1'b0);
        exec_seq(1'b1, 8'h01, 8'hA3, 1'b1, 1'b0, 1'b0);
        fetch_seq(8'hFE, 8'h93, 0, 1'b1, 1'b0);
        exec_seq(1'b1, 8'hFF, 8'h93, 1'b1, 1'b0, 1'b0);
        fetch_seq(8'h02, 8'hC4, 0, 1'b1, 1'b0);
        exec_seq(1'b1, 8'h03, 8'hC4, 1'b1, 1'b0, 1'b0);
        fetch_seq(8'h03, 8'hC4, 0, 1'b1, 1'b0);
        exec_seq(1'b1, 8'h04, 8'hC4, 1'b1, 1'b0, 1'b1);
        fetch_seq(8'h08, 8'h61, 0, 1'b1, 1'b0);
        exec_seq(1'b1, 8'h09, 8'h61, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        expect_bus("run_off_idle", 1'b0, 1'b0, 8'h09, 1'b0);

        // Single-step: pulses, then step held high.
        do_reset();
        p = 8'h00;
        for (int k = 0; k < 2; k++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            expect_bus("step_idle", 1'b0, 1'b0, p, 1'b0);
            fetch_seq(p, 8'h61, 0, 1'b0, 1'b0);
            exec_seq(1'b1, p + 8'd1, 8'h61, 1'b0, 1'b0, 1'b0);
            p = p + 8'd1;
            for (int j = 0; j < 3; j++) begin
                tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
                expect_bus("step_quiet", 1'b0, 1'b0, p, 1'b0);
            end
        end
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            expect_bus("step_held_idle", 1'b0, 1'b0, p, 1'b0);
            fetch_seq(p, 8'h61, 0, 1'b0, 1'b1);
            exec_seq(1'b1, p + 8'd1, 8'h61, 1'b0, 1'b1, 1'b0);
            p = p + 8'd1;
        end

        // Ready on the last permitted wait cycle wins; then a stuck fetch faults.
        do_reset();
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        fetch_seq(8'h00, 8'h61, 15, 1'b1, 1'b0);
        exec_seq(1'b1, 8'h01, 8'h61, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            chk("stuck.req",   32'(bus.mem_req_o), 32'd1);
            chk("stuck.fault", 32'(bus.fault_o),   32'd0);
        end
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("fault.fault", 32'(bus.fault_o),   32'd1);
        chk("fault.req",   32'(bus.mem_req_o), 32'd0);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
        chk("fault.sticky", 32'(bus.fault_o), 32'd1);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("fault_rst.fault", 32'(bus.fault_o), 32'd0);
        expect_bus("fault_rst", 1'b0, 1'b0, 8'h00, 1'b0);
        chk("fault_rst.pc", 32'(bus.pc_o), 32'd0);

        // Reset during a MEM wait, with ready arriving in the reset cycle.
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        fetch_seq(8'h00, 8'h25, 0, 1'b1, 1'b0);
        exec_seq(1'b0, 8'h01, 8'h25, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        expect_bus("load_wait", 1'b1, 1'b0, 8'hE5, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("rst_mem.exec", 32'(bus.exec_o), 32'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        expect_bus("rst_mem_after", 1'b0, 1'b0, 8'h00, 1'b0);
        chk("rst_mem_after.pc", 32'(bus.pc_o), 32'd0);
        chk("rst_mem_after.ir", 32'(bus.ir_o), 32'd0);

        // Random program with random wait states against the model.
        begin
            int          k_instr;
            int          fetches;
            int          wait_left;
            int          budget;
            logic        prev_exec;
            logic [17:0] e;
            k_instr = 60;
            for (int i = 0; i < 256; i++) begin
                mem[i] = 8'($urandom);
                if (mem[i][7:4] == 4'hF) mem[i][7:4] = 4'h8;
                zbit[i] = 1'($urandom_range(0, 1));
            end
            m_pc = 8'h00;
            exp_q.delete();
            for (int i = 0; i < k_instr; i++) model_instr();
            do_reset();
            fetches   = 0;
            wait_left = $urandom_range(0, 3);
            budget    = 3000;
            prev_exec = 1'b0;
            while (exp_q.size() > 0 && budget > 0) begin
                budget--;
                @(negedge clk);
                rst         = 1'b0;
                bus.step_i  = 1'b0;
                bus.run_i   = (fetches < k_instr);
                bus.zero_i  = zbit[bus.pc_o];
                bus.mem_ready_i = 1'b0;
                if (bus.mem_req_o) begin
                    if (wait_left == 0) begin
                        bus.mem_ready_i = 1'b1;
                        bus.mem_rdata_i = mem[bus.mem_addr_o];
                    end else begin
                        wait_left--;
                    end
                end
                #1;
                chk("rand.exec_double", 32'(bus.exec_o & prev_exec), 32'd0);
                prev_exec = bus.exec_o;
                if (bus.mem_req_o && bus.mem_ready_i) begin
                    wait_left = $urandom_range(0, 3);
                    if (exp_q.size() == 0) begin
                        chk("rand.unexpected_bus", 32'(bus.mem_addr_o), 32'h1ff);
                    end else begin
                        e = exp_q.pop_front();
                        if (e[17:16] == 2'd1) fetches++;
                        chk("rand.bus", {15'd0, 1'b1, bus.mem_addr_o, 7'b0, bus.mem_we_o},
                            {15'd0, e[16], e[15:0]});
                    end
                end
                if (bus.exec_o) begin
                    if (exp_q.size() == 0) begin
                        chk("rand.unexpected_exec", 32'(bus.ir_o), 32'h1ff);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rand.exec", {14'd0, 2'd2, bus.ir_o, bus.pc_o}, {14'd0, e});
                    end
                end
            end
            chk("rand.all_retired", 32'(exp_q.size()), 32'd0);
            for (int i = 0; i < 3; i++) begin
                tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
                chk("rand.idle_req", 32'(bus.mem_req_o), 32'd0);
                chk("rand.final_pc", 32'(bus.pc_o),      32'(m_pc));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/kt8_sequencer.md
# kt8_sequencer

Fetch/execute controller for the KT8 CPU. Sequences each instruction through a single shared 8-bit memory port, holding the current instruction for the decoder and issuing one `exec_o` strobe per instruction. Every register load and RAM write produced by the decoder is qualified with `exec_o`. Also owns the program counter, relative jumps, run/single-step control, halt, and a bus-timeout fault.

## Interface
- `RESET_PC`, default 8'h00: PC value after reset.
- `DATA_BASE`, default 8'hE0: data aperture. Data address = `DATA_BASE | {3'b000, ir[4:0]}`.
- `BUS_TIMEOUT`, default 15: maximum wait cycles for `mem_ready_i` before entering FAULT (range 1–255).
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `run_i` in 1: 1 = free-run; 0 = stop after the current instruction.
- `step_i` in 1: in IDLE, one high cycle starts exactly one instruction.
- `zero_i` in 1: ALU zero flag (R == 0), sampled in EXEC.
- `mem_req_o` out 1: memory request, held until ready.
- `mem_we_o` out 1: write qualifier. Valid only while `mem_req_o` = 1.
- `mem_addr_o` out 8: memory address.
- `mem_ready_i` in 1: transfer completes in the cycle this is high. Read data is valid in the same cycle.
- `mem_rdata_i` in 8: read data.
- `ir_o` out 8: current instruction register, to the decoder.
- `exec_o` out 1: one-cycle commit strobe.
- `pc_o` out 8: program counter.
- `halted_o` out 1: HALT state.
- `fault_o` out 1: FAULT state.

## Operation
- States: IDLE, FETCH, EXEC, MEM, HALT, FAULT. Reset enters IDLE.
- Reset values: `pc_o` = `RESET_PC`, `ir_o` = 8'h00. All other outputs are 0, except `mem_addr_o`, which shows the PC (`RESET_PC`).
- `ir_o` = 8'h00 decodes as load A. This is harmless because `exec_o` = 0.
- IDLE → FETCH when `run_i` or `step_i` is high.
- FETCH: `mem_req_o` = 1, `mem_addr_o` = PC, `mem_we_o` = 0. On `mem_ready_i`: `ir` ← `mem_rdata_i`, PC ← PC + 1 (mod 256, so 8'hFF wraps to 8'h00), then go to EXEC.
- EXEC decodes `ir`:
  - `000aaaaa`, `001aaaaa`, `010aaaaa` → MEM, with no strobe.
  - All other opcodes: `exec_o` = 1 for one cycle, then apply the jump below.
  - Next state: HALT if `ir[7:4]` = 4'b1111; otherwise FETCH if `run_i`, else IDLE.
- Jumps are relative to the already-incremented PC, with d = `ir[3:0]`, all mod 256:
  - `1001dddd`: PC ← PC + d.
  - `1010dddd`: PC ← PC − d.
  - `1100dddd`: PC ← PC + d if `zero_i`, else no change.
  - Other undefined opcodes are NOPs that still strobe `exec_o`.
- MEM: `mem_req_o` = 1, `mem_addr_o` = data address, `mem_we_o` = 1 iff `ir[7:5]` = 3'b010.
  - `exec_o` = 1 in the `mem_ready_i` cycle, so loads capture `mem_rdata_i` and the store write enable commits.
  - Then go to FETCH or IDLE on `run_i`.
- HALT and FAULT are sticky until `rst_i`. `mem_req_o` = 0 in both.
- `mem_addr_o` = PC and `mem_we_o` = 0 whenever `mem_req_o` = 0.

## Timing
- Zero-wait latency: non-memory instruction = 2 cycles (FETCH, EXEC); memory instruction = 3 cycles (FETCH, EXEC, MEM).
- Each wait cycle extends FETCH or MEM by 1.
- `mem_req_o`, `mem_addr_o` and `mem_we_o` are stable from assertion until the ready cycle. The request drops (or changes address) in the next cycle.
- Wait counter:
  - Clears on entry to FETCH or MEM.
  - Increments each cycle with `mem_req_o` = 1 and `mem_ready_i` = 0.
  - When it reaches `BUS_TIMEOUT` → FAULT on the next edge. A ready arriving in that same cycle wins.
- `run_i` deasserted mid-instruction: the instruction completes (including MEM), then IDLE. No new fetch starts.
- `step_i` held high in IDLE starts one instruction per IDLE visit (3 cycles per ALU instruction when stepping).
- `rst_i` takes priority in every state. All state returns to reset values on that edge, and a `mem_ready_i` in the reset cycle is ignored.
- `exec_o` is never high in IDLE, FETCH, HALT or FAULT, and never high for two consecutive cycles.

## Test plan
- Zero-wait program [0x61, 0x85, 0xF0] with `run_i` = 1:
  - Fetch addresses 0, 1, 2.
  - `exec_o` high in cycles 2, 4, 6.
  - `halted_o` = 1 after cycle 6, with `pc_o` = 3.
- Store `0x43` at PC 0x10 with 2 wait states:
  - MEM request at addr 0xE3 with `mem_we_o` = 1, held 3 cycles.
  - `exec_o` only in the ready cycle.
  - Next fetch at 0x11.
- Jumps:
  - `0xA1` at 0x20 → PC stays 0x20 (self-loop).
  - `0x93` at 0xFE → PC = 0x02 (wrap).
  - `0xC4` with `zero_i` = 0 → PC + 1 only.
- Single-step with `run_i` = 0: each `step_i` pulse yields exactly one `exec_o`. `step_i` held high gives one instruction per IDLE visit.
- `mem_ready_i` stuck low during fetch with `BUS_TIMEOUT` = 15 → FAULT entered after 15 wait cycles, `fault_o` = 1, `mem_req_o` = 0. `rst_i` then returns to IDLE with PC = 0x00.
- `rst_i` asserted during a MEM wait → next cycle: `mem_req_o` = 0, `pc_o` = `RESET_PC`, no `exec_o`.
